spi_master_arbiter: RTL

SPI master that shares one SPI bus among `NUM_REQ` on-chip requesters. Each requester issues one full-duplex byte transfer at a time. The block arbitrates pending requests (round-robin), drives `cs`/`sclk`/`mosi` for the granted requester in any of the four `cpol`/`cpha` modes, captures `miso`, and returns the received byte. It is the bus-side counterpart of `spi_slave`, and sits between register-level clients and the off-chip (or loopback) SPI slave.

---
 rtl/spi_master_arbiter_if.sv | 16 +
 rtl/spi_master_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/spi_master_arbiter_if.sv
// Client-side bundle of spi_master_arbiter: requests, per-requester tx bytes, grant and completion.
interface spi_master_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] tx_data;
    logic                 cpol;
    logic                 cpha;
    logic [NUM_REQ-1:0]   gnt;
    logic                 done;
    logic [7:0]           rx_data;
    logic                 busy;

    modport master (output req, tx_data, cpol, cpha, input gnt, done, rx_data, busy);
    modport slave  (input req, tx_data, cpol, cpha, output gnt, done, rx_data, busy);
endinterface

// File: rtl/spi_master_arbiter.sv
// Arbitrated SPI master: NUM_REQ clients share one SPI bus, one full-duplex byte per grant, all cpol/cpha modes.
// Round-robin by default; define SPI_ARB_FIXED_PRIO_EN for fixed priority with req[0] highest.
module spi_master_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int CLK_DIV = 4
) (
    input  logic                clk,
    input  logic                reset,
    spi_master_arbiter_if.slave bus,
    output logic                sclk,
    output logic                cs,
    output logic                mosi,
    input  logic                miso
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;
    state_t state, state_nxt;

    logic [DW-1:0]      div_cnt;
    logic [3:0]         half_cnt;
    logic [3:0]         edge_idx;
    logic               div_last;
    logic               edge_en;
    logic               sample_en;
    logic               shift_en;
    logic               cpol_q;
    logic               cpha_q;
    logic               sclk_q;
    logic [7:0]         tx_sr;
    logic [7:0]         rx_sr;
    logic [7:0]         rx_q;
    logic [7:0]         tx_sel;
    logic [NUM_REQ-1:0] gnt_q;
    logic               done_q;
    logic               busy_c;
    logic               miso_meta;
    logic               miso_sync;
    logic [IW-1:0]      win;
`ifndef SPI_ARB_FIXED_PRIO_EN
    logic [IW-1:0]      last;
`endif

    // Lowest set index wins; round-robin then overrides with the lowest set index above `last`.
    always_comb begin
        win    = '0;
        tx_sel = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (bus.req[k]) win = IW'(k);
`ifndef SPI_ARB_FIXED_PRIO_EN
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (bus.req[k] && (IW'(k) > last)) win = IW'(k);
`endif
        for (int k = 0; k < NUM_REQ; k++)
            if (IW'(k) == win) tx_sel = bus.tx_data[8*k +: 8];
    end

    // edge_idx numbers the 16 sclk edges; even = leading, odd = trailing.
    assign div_last  = (div_cnt == DIV_LAST);
    assign edge_en   = div_last && ((state == SETUP) || ((state == XFER) && (half_cnt != 4'd15)));
    assign edge_idx  = (state == SETUP) ? 4'd0 : half_cnt + 4'd1;
    assign sample_en = edge_en && (~edge_idx[0] ^ cpha_q);
    assign shift_en  = edge_en && !(~edge_idx[0] ^ cpha_q) &&
                       (cpha_q ? (edge_idx != 4'd0) : (edge_idx != 4'd15));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        cs        = 1'b1;
        busy_c    = 1'b1;
        case (state)
            IDLE: begin
                busy_c = 1'b0;
                if (|bus.req) state_nxt = SETUP;
            end
            SETUP: begin
                cs = 1'b0;
                if (div_last) state_nxt = XFER;
            end
            XFER: begin
                cs = 1'b0;
                if (div_last && (half_cnt == 4'd15)) state_nxt = HOLD;
            end
            HOLD: begin
                cs = 1'b0;
                if (div_last) state_nxt = GAP;
            end
            GAP: begin
                if (div_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt   <= '0;
            half_cnt  <= '0;
            sclk_q    <= 1'b0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            rx_q      <= '0;
            gnt_q     <= '0;
            done_q    <= 1'b0;
            miso_meta <= 1'b0;
            miso_sync <= 1'b0;
`ifndef SPI_ARB_FIXED_PRIO_EN
            last      <= IW'(NUM_REQ - 1);
`endif
        end else begin
            miso_meta <= miso;
            miso_sync <= miso_meta;
            done_q    <= 1'b0;
            div_cnt   <= ((state == IDLE) || div_last) ? '0 : div_cnt + 1'b1;
            if (edge_en) begin
                half_cnt <= edge_idx;
                sclk_q   <= ~sclk_q;
            end
            if (sample_en) rx_sr <= {rx_sr[6:0], miso_sync};
            if (shift_en)  tx_sr <= {tx_sr[6:0], 1'b0};
            case (state)
                IDLE: begin
                    sclk_q <= bus.cpol;
                    if (|bus.req) begin
                        gnt_q  <= NUM_REQ'(1) << win;
                        tx_sr  <= tx_sel;
                        cpol_q <= bus.cpol;
                        cpha_q <= bus.cpha;
`ifndef SPI_ARB_FIXED_PRIO_EN
                        last   <= win;
`endif
                    end
                end
                HOLD: begin
                    if (div_last) begin
                        done_q <= 1'b1;
                        rx_q   <= rx_sr;
                    end
                end
                GAP: begin
                    if (div_cnt == '0) gnt_q <= '0;
                end
                default: ;
            endcase
        end
    end

    assign sclk        = sclk_q;
    assign mosi        = ~cs & tx_sr[7];
    assign bus.gnt     = gnt_q;
    assign bus.done    = done_q;
    assign bus.rx_data = rx_q;
    assign bus.busy    = busy_c;
endmodule
